// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-outstanding peripheral bridge.
// Each access runs IDLE/RESP -> ISSUE -> RESP and returns a response pulse to the winner.
module bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic [31:0] PrAddr,
    output logic [31:0] PrWD,
    output logic [3:0]  PrByteEn,
    input  logic [31:0] PrRD,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        lastGnt_q, winId_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  byteEn_q;
    logic [31:0] m0Rdata_q, m1Rdata_q;
    logic        m0Rvalid_q, m1Rvalid_q;

    logic        anyReq;
    logic        winner;
    logic        load;

    // Requests are ignored while in ISSUE; a tie goes to the master that did not win last.
    always_comb begin
        anyReq  = m0_req | m1_req;
        winner  = 1'b0;
        load    = 1'b0;
        state_d = state_q;
        if (m0_req && m1_req) begin
            winner = ~lastGnt_q;
        end else begin
            winner = m1_req;
        end
        case (state_q)
            IDLE, RESP: begin
                if (anyReq) begin
                    state_d = ISSUE;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lastGnt_q  <= 1'b1;
            winId_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            byteEn_q   <= 4'h0;
            m0Rdata_q  <= 32'h0;
            m1Rdata_q  <= 32'h0;
            m0Rvalid_q <= 1'b0;
            m1Rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m0Rvalid_q <= 1'b0;
            m1Rvalid_q <= 1'b0;
            if (load) begin
                winId_q   <= winner;
                lastGnt_q <= winner;
                addr_q    <= winner ? m1_addr   : m0_addr;
                wdata_q   <= winner ? m1_wdata  : m0_wdata;
                byteEn_q  <= winner ? m1_byteen : m0_byteen;
            end
            // Writes complete with zero data so both masters see a uniform acknowledgement.
            if (state_q == RESP) begin
                if (winId_q) begin
                    m1Rdata_q  <= (byteEn_q == 4'h0) ? PrRD : 32'h0;
                    m1Rvalid_q <= 1'b1;
                end else begin
                    m0Rdata_q  <= (byteEn_q == 4'h0) ? PrRD : 32'h0;
                    m0Rvalid_q <= 1'b1;
                end
            end
        end
    end

    assign m0_gnt    = (state_q == ISSUE) && !winId_q;
    assign m1_gnt    = (state_q == ISSUE) &&  winId_q;
    assign m0_rdata  = m0Rdata_q;
    assign m1_rdata  = m1Rdata_q;
    assign m0_rvalid = m0Rvalid_q;
    assign m1_rvalid = m1Rvalid_q;
    assign PrAddr    = addr_q;
    assign PrWD      = wdata_q;
    assign PrByteEn  = (state_q == ISSUE) ? byteEn_q : 4'h0;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; every expectation is hand-computed.
module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] PrAddr, PrWD, PrRD;
    logic [3:0]  PrByteEn;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic overlapSeen = 1'b0;

    bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_byteen (m0_byteen),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_byteen (m1_byteen),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .PrAddr    (PrAddr),
        .PrWD      (PrWD),
        .PrByteEn  (PrByteEn),
        .PrRD      (PrRD),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((m0_gnt && m1_gnt) || (m0_rvalid && m1_rvalid)) overlapSeen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic master, input logic req, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] byteen);
        if (master) begin
            m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_byteen = byteen;
        end else begin
            m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_byteen = byteen;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rvCount;
        logic w;
        reset = 1'b0;
        PrRD  = 32'h0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        #3;
        checkOutput("rst_busy",   {31'h0, busy}, 32'h0);
        checkOutput("rst_byteen", {28'h0, PrByteEn}, 32'h0);
        checkOutput("rst_gnt",    {30'h0, m0_gnt, m1_gnt}, 32'h0);
        checkOutput("rst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
        checkOutput("rst_rdata0", m0_rdata, 32'h0);
        checkOutput("rst_rdata1", m1_rdata, 32'h0);
        checkOutput("rst_addr",   PrAddr, 32'h0);
        tick; tick;
        reset = 1'b1;

        // Single read by m0
        applyStimulus(1'b0, 1'b1, 32'h0000_1000, 32'h0, 4'h0);
        tick;
        checkOutput("rd_gnt",    {30'h0, m0_gnt, m1_gnt}, 32'h2);
        checkOutput("rd_addr",   PrAddr, 32'h0000_1000);
        checkOutput("rd_byteen", {28'h0, PrByteEn}, 32'h0);
        checkOutput("rd_busy",   {31'h0, busy}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        PrRD = 32'hDEAD_BEEF;
        tick;
        checkOutput("rd_resp_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);
        checkOutput("rd_resp_rv",  {31'h0, m0_rvalid}, 32'h0);
        tick;
        checkOutput("rd_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h2);
        checkOutput("rd_rdata",  m0_rdata, 32'hDEAD_BEEF);
        checkOutput("rd_idle",   {31'h0, busy}, 32'h0);
        tick;
        checkOutput("rd_rv_pulse", {31'h0, m0_rvalid}, 32'h0);
        checkOutput("rd_hold",     m0_rdata, 32'hDEAD_BEEF);

        // Single write by m1
        applyStimulus(1'b1, 1'b1, 32'h0000_7F00, 32'h1234_5678, 4'hF);
        tick;
        checkOutput("wr_gnt",    {30'h0, m0_gnt, m1_gnt}, 32'h1);
        checkOutput("wr_byteen", {28'h0, PrByteEn}, 32'hF);
        checkOutput("wr_wd",     PrWD, 32'h1234_5678);
        checkOutput("wr_addr",   PrAddr, 32'h0000_7F00);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;
        checkOutput("wr_resp_be", {28'h0, PrByteEn}, 32'h0);
        checkOutput("wr_resp_wd", PrWD, 32'h1234_5678);
        tick;
        checkOutput("wr_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h1);
        checkOutput("wr_rdata",  m1_rdata, 32'h0);
        checkOutput("wr_m0hold", m0_rdata, 32'hDEAD_BEEF);
        tick;
        checkOutput("wr_idle_be",   {28'h0, PrByteEn}, 32'h0);
        checkOutput("wr_idle_addr", PrAddr, 32'h0000_7F00);

        // Tie after reset: m0 first, then alternate
        reset = 1'b0;
        tick; tick;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            w = i[0];
            tick;
            checkOutput($sformatf("tie_gnt%0d", i), {30'h0, m0_gnt, m1_gnt}, w ? 32'h1 : 32'h2);
            checkOutput($sformatf("tie_addr%0d", i), PrAddr, w ? 32'h0000_0200 : 32'h0000_0100);
            if (i > 0) begin
                checkOutput($sformatf("tie_rv%0d", i), {30'h0, m0_rvalid, m1_rvalid}, w ? 32'h2 : 32'h1);
                checkOutput($sformatf("tie_rd%0d", i), w ? m0_rdata : m1_rdata, 32'hC0DE_0000 | (i - 1));
            end
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            PrRD = 32'hC0DE_0000 | i;
            tick;
            checkOutput($sformatf("tie_resp%0d", i), {30'h0, m0_gnt, m1_gnt}, 32'h0);
        end
        tick;
        checkOutput("tie_last_rv", {30'h0, m0_rvalid, m1_rvalid}, 32'h1);
        checkOutput("tie_last_rd", m1_rdata, 32'hC0DE_0003);
        checkOutput("tie_idle",    {31'h0, busy}, 32'h0);

        // Back-to-back accesses from m0 only
        rvCount = 0;
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
        PrRD = 32'h0BAD_F00D;
        for (int k = 0; k < 3; k++) begin
            tick;
            checkOutput($sformatf("b2b_gnt%0d", k), {30'h0, m0_gnt, m1_gnt}, 32'h2);
            checkOutput($sformatf("b2b_busyI%0d", k), {31'h0, busy}, 32'h1);
            rvCount += int'(m0_rvalid);
            if (k == 2) m0_req = 1'b0;
            tick;
            checkOutput($sformatf("b2b_busyR%0d", k), {31'h0, busy}, 32'h1);
            rvCount += int'(m0_rvalid);
        end
        tick;
        rvCount += int'(m0_rvalid);
        checkOutput("b2b_rvcount", rvCount, 32'd3);
        checkOutput("b2b_rdata",   m0_rdata, 32'h0BAD_F00D);

        // Reset during RESP of an m1 read
        applyStimulus(1'b1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
        tick;
        checkOutput("mid_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h1);
        m1_req = 1'b0;
        PrRD = 32'h1111_2222;
        tick;
        checkOutput("mid_inresp", {31'h0, busy}, 32'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_busy",   {31'h0, busy}, 32'h0);
        checkOutput("mid_byteen", {28'h0, PrByteEn}, 32'h0);
        checkOutput("mid_addr",   PrAddr, 32'h0);
        checkOutput("mid_rdata",  {m0_rdata | m1_rdata}, 32'h0);
        checkOutput("mid_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
        tick; tick;
        reset = 1'b1;
        rvCount = 0;
        tick;
        rvCount += int'(m1_rvalid);
        tick;
        rvCount += int'(m1_rvalid);
        checkOutput("mid_no_rv", rvCount, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0000_2004, 32'h0, 4'h0);
        tick;
        checkOutput("post_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h1);
        m1_req = 1'b0;
        PrRD = 32'h55AA_55AA;
        tick;
        tick;
        checkOutput("post_rv", {30'h0, m0_rvalid, m1_rvalid}, 32'h1);
        checkOutput("post_rd", m1_rdata, 32'h55AA_55AA);

        // m1 request withdrawn before it could be granted
        applyStimulus(1'b0, 1'b1, 32'h0000_4000, 32'h0, 4'h0);
        tick;
        checkOutput("wd_gnt0", {30'h0, m0_gnt, m1_gnt}, 32'h2);
        m0_req = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h0000_5000, 32'h0, 4'h0);
        PrRD = 32'h7777_8888;
        tick;
        m1_req = 1'b0;
        checkOutput("wd_resp", {30'h0, m0_gnt, m1_gnt}, 32'h0);
        tick;
        checkOutput("wd_rv",   {30'h0, m0_rvalid, m1_rvalid}, 32'h2);
        checkOutput("wd_busy", {31'h0, busy}, 32'h0);
        tick;
        checkOutput("wd_after", {29'h0, m1_gnt, m1_rvalid, busy}, 32'h0);
        checkOutput("wd_m1rd",  m1_rdata, 32'h55AA_55AA);

        checkOutput("no_overlap", {31'h0, overlapSeen}, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters: none; the data bus is fixed at 32 bits, byte enables at 4 bits, and the read latency at 1 cycle.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 m0_req  in  1  master 0 (CPU) access request, level.
REQ-005 m0_addr  in  32  master 0 byte address.
REQ-006 m0_wdata  in  32  master 0 write data.
REQ-007 m0_byteen  in  4  master 0 byte enables; 4'b0000 = read.
REQ-008 m0_gnt  out  1  master 0 grant pulse.
REQ-009 m0_rdata  out  32  master 0 response data.
REQ-010 m0_rvalid  out  1  master 0 response pulse.
REQ-011 m1_req, m1_addr, m1_wdata, m1_byteen, m1_gnt, m1_rdata, m1_rvalid: master 1 (DMA), widths and meaning identical to the m0_* ports.
REQ-012 PrAddr  out  32  address to bridge.
REQ-013 PrWD  out  32  write data to bridge.
REQ-014 PrByteEn  out  4  byte enables to bridge.
REQ-015 PrRD  in  32  read data from bridge.
REQ-016 busy  out  1  high whenever state != IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, RESP; 2-bit state register.
REQ-018 Arbitration is evaluated only on edges leaving IDLE or RESP; any mN_req high leads to ISSUE, otherwise to IDLE.
REQ-019 Round-robin: a 1-bit last-grant register last_gnt; with both req high, grant the master != last_gnt; with one req high, grant that master.
REQ-020 On the edge entering ISSUE: latch winner's addr/wdata/byteen into internal regs, record the winner id, update last_gnt to the winner.
REQ-021 ISSUE: winner's mN_gnt = 1 (exactly one cycle); PrAddr/PrWD = latched values; PrByteEn = latched byteen.
REQ-022 ISSUE always transitions to RESP.
REQ-023 RESP: PrAddr/PrWD hold the latched values; PrByteEn = 4'b0000 (no second write).
REQ-024 IDLE: PrByteEn = 4'b0000; PrAddr/PrWD hold the last latched values.
REQ-025 Edge leaving RESP: capture PrRD into the winner's mN_rdata if the latched byteen == 0, else capture 32'h0; the winner's mN_rvalid = 1 for the following cycle only (write completions also acknowledged).
REQ-026 Latency: req sampled at edge E0 -> gnt high cycle after E0 -> rvalid high two cycles after gnt; peak throughput one access per 2 cycles (RESP -> ISSUE back-to-back).
REQ-027 Master handshake: addr/wdata/byteen stable while req high and before gnt; the master drops req in the cycle after gnt unless issuing a new access; req high during ISSUE is ignored.
REQ-028 The non-winning master's rdata holds its previous value; its rvalid stays 0.
REQ-029 m0_gnt and m1_gnt never high together; m0_rvalid and m1_rvalid never high together.
REQ-030 A req that drops before grant is dropped silently (no gnt, no rvalid).
REQ-031 All outputs are registered or decoded from state/latched regs only; no combinational path from mN_req to any Pr* output.

Reset
REQ-032 reset low asynchronously forces: state = IDLE, last_gnt = 1 (master 0 wins the first tie), latched addr/wdata/byteen = 0, all gnt/rvalid = 0, both rdata = 0, busy = 0, PrByteEn = 0.
REQ-033 Reset asserted during ISSUE or RESP abandons the access: no rvalid is issued after release; the first post-reset arbitration follows REQ-032.
REQ-034 After reset deassertion, the first arbitration is the first rising edge with reset high.

Verification
REQ-035 Single read: m0 read addr 32'h0000_1000, PrRD = 32'hDEAD_BEEF during RESP -> m0_gnt 1 cycle, PrByteEn = 0, m0_rvalid 1 cycle later with m0_rdata = 32'hDEAD_BEEF.
REQ-036 Single write: m1 addr 32'h0000_7F00, wdata 32'h1234_5678, byteen 4'b1111 -> PrByteEn = 4'b1111 only in ISSUE, m1_rvalid pulse with m1_rdata = 0.
REQ-037 Tie after reset: m0 and m1 both req in the same cycle and held -> grant order m0, m1, m0, m1; gnt pulses spaced 2 cycles apart; no overlapping gnt/rvalid.
REQ-038 Back-to-back same master: m0 req held for 3 accesses, m1 idle -> 3 gnt pulses every 2 cycles, busy continuously high, 3 rvalid pulses.
REQ-039 Reset mid-access: reset low during RESP of an m1 read -> all outputs return to REQ-032 values immediately, no m1_rvalid after release; a subsequent m1 request completes normally.
REQ-040 Withdrawn request: m1 req high 1 cycle during an m0 ISSUE, then low -> m1 never granted, no m1_rvalid.
